// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized input, mid-bit sampling, LSB first.
// One-cycle data_valid / frame_err pulses; BREAK absorbs a held-low line.
module uart_rx #(
    parameter int DELAY_FRAMES = 2812,
    parameter int BIT_PER_WORD = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_pin,
    output logic [BIT_PER_WORD:0] data,
    output logic                  data_valid,
    output logic                  frame_err,
    output logic                  busy,
    output logic [2:0]            led
);

    localparam int IDX_W = (BIT_PER_WORD > 0) ? $clog2(BIT_PER_WORD + 1) : 1;
    localparam logic [24:0] HALF_LAST = 25'(DELAY_FRAMES / 2 - 1);
    localparam logic [24:0] BIT_LAST = 25'(DELAY_FRAMES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BIT_PER_WORD);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            sync_q;
    logic [24:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BIT_PER_WORD:0] shift_q, shift_d;
    logic [BIT_PER_WORD:0] data_q, data_d;
    logic                  dv_q, dv_d;
    logic                  fe_q, fe_d;
    logic                  rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], rx_pin};
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        fe_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // Re-check the line at mid start bit to reject glitches
                if (cnt_q == HALF_LAST) begin
                    if (!rx_s) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 25'd1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    shift_d[idx_q] = rx_s;
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 25'd1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 25'd1;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        led = 3'b010;
        if (state_q == IDLE) begin
            led = 3'b001;
        end else if (state_q == BREAK) begin
            led = 3'b100;
        end
    end

    assign busy       = (state_q != IDLE);
    assign data       = data_q;
    assign data_valid = dv_q;
    assign frame_err  = fe_q;

endmodule
